// File: rtl/tb_run_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_run_monitor_pkg : shared types for the run-termination monitor  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tb_run_monitor_pkg;

  localparam int CAUSE_W = 2;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_SRC    = 2'd1,
    CAUSE_MAXCYC = 2'd2,
    CAUSE_WDOG   = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/tb_run_monitor_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_run_monitor_cnt : saturating up-counter with enable and clear   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_run_monitor_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear dominates; the counter parks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/tb_run_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_run_monitor : end-of-run detector, counters and final capture   |
// | optional watchdog: TB_RUN_MON_WATCHDOG_EN             rev 1.0      |
// +--------------------------------------------------------------------+
module tb_run_monitor
  import tb_run_monitor_pkg::*;
#(
  parameter int               N_SRC          = 4,
  parameter int               VAL_W          = 32,
  parameter int               CNT_W          = 32,
  parameter int               STARTUP_CYCLES = 2,
  parameter logic [N_SRC-1:0] FAIL_MASK      = '0,
  parameter int               WDOG_CYCLES    = 1024,
  localparam int              IDX_W          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   retire_i,
  input  logic [31:0]            pc_i,
  input  logic [CNT_W-1:0]       max_cycles_i,
  input  logic [N_SRC-1:0]       src_valid_i,
  input  logic [N_SRC*VAL_W-1:0] src_value_i,
  output logic                   running_o,
  output logic                   done_o,
  output logic                   done_pulse_o,
  output logic                   pass_o,
  output logic                   fail_o,
  output logic                   timeout_o,
  output logic [CAUSE_W-1:0]     cause_o,
  output logic [IDX_W-1:0]       src_idx_o,
  output logic [VAL_W-1:0]       exit_value_o,
  output logic [CNT_W-1:0]       fin_cycle_o,
  output logic [CNT_W-1:0]       fin_instr_o,
  output logic [31:0]            fin_pc_o,
  output logic [CNT_W-1:0]       cycle_cnt_o,
  output logic [CNT_W-1:0]       instr_cnt_o
);

  state_e             state_q, state_d;
  logic               done_q, done_d, pulse_q, pulse_d;
  logic               pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;
  cause_e             cause_q, cause_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VAL_W-1:0]   exit_q, exit_d;
  logic [CNT_W-1:0]   fin_cycle_q, fin_cycle_d, fin_instr_q, fin_instr_d;
  logic [31:0]        fin_pc_q, fin_pc_d;

  logic [CNT_W-1:0]   holdoff_cnt, cycle_cnt, instr_cnt;
  logic               in_wait, in_run, term;
  logic               src_hit, src_fm, max_hit, wdog_hit;
  logic [IDX_W-1:0]   src_idx;
  logic [VAL_W-1:0]   src_val;

  assign in_wait = (state_q == ST_WAIT);
  assign in_run  = (state_q == ST_RUN);

  tb_run_monitor_cnt #(.W(CNT_W)) u_holdoff_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(in_wait), .clr_i(1'b0), .cnt_o(holdoff_cnt)
  );

  // Counters stop on the terminating edge so live and captured values agree.
  tb_run_monitor_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(in_run && !term), .clr_i(1'b0), .cnt_o(cycle_cnt)
  );

  tb_run_monitor_cnt #(.W(CNT_W)) u_instr_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i((in_wait || in_run) && retire_i && !term),
    .clr_i(1'b0), .cnt_o(instr_cnt)
  );

`ifdef TB_RUN_MON_WATCHDOG_EN
  logic [CNT_W-1:0] wdog_cnt;

  tb_run_monitor_cnt #(.W(CNT_W)) u_wdog_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(in_run && !retire_i),
    .clr_i(!in_run || retire_i), .cnt_o(wdog_cnt)
  );

  assign wdog_hit = in_run && (wdog_cnt >= CNT_W'(WDOG_CYCLES));
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_hit    = 1'b0;
`endif

  // Descending scan leaves the lowest active index as the winner.
  always_comb begin
    src_hit = 1'b0;
    src_idx = '0;
    src_val = '0;
    src_fm  = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_valid_i[i]) begin
        src_hit = 1'b1;
        src_idx = IDX_W'(i);
        src_val = src_value_i[i*VAL_W +: VAL_W];
        src_fm  = FAIL_MASK[i];
      end
    end
    src_hit = src_hit && (in_wait || in_run);
  end

  assign max_hit = in_run && (max_cycles_i != '0) && (cycle_cnt >= max_cycles_i);
  assign term    = src_hit || max_hit || wdog_hit;

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    pulse_d     = 1'b0;
    pass_d      = pass_q;
    fail_d      = fail_q;
    tmo_d       = tmo_q;
    cause_d     = cause_q;
    idx_d       = idx_q;
    exit_d      = exit_q;
    fin_cycle_d = fin_cycle_q;
    fin_instr_d = fin_instr_q;
    fin_pc_d    = fin_pc_q;
    if (in_wait && (holdoff_cnt >= CNT_W'(STARTUP_CYCLES))) begin
      state_d = ST_RUN;
    end
    if (term) begin
      state_d     = ST_DONE;
      done_d      = 1'b1;
      pulse_d     = 1'b1;
      fin_cycle_d = cycle_cnt;
      fin_instr_d = instr_cnt;
      fin_pc_d    = pc_i;
      if (src_hit) begin
        cause_d = CAUSE_SRC;
        idx_d   = src_idx;
        exit_d  = src_val;
        pass_d  = (src_val == '0) && !src_fm;
        fail_d  = (src_val != '0) || src_fm;
      end else begin
        cause_d = max_hit ? CAUSE_MAXCYC : CAUSE_WDOG;
        tmo_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_WAIT;
      done_q      <= 1'b0;
      pulse_q     <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      tmo_q       <= 1'b0;
      cause_q     <= CAUSE_NONE;
      idx_q       <= '0;
      exit_q      <= '0;
      fin_cycle_q <= '0;
      fin_instr_q <= '0;
      fin_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      pulse_q     <= pulse_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      tmo_q       <= tmo_d;
      cause_q     <= cause_d;
      idx_q       <= idx_d;
      exit_q      <= exit_d;
      fin_cycle_q <= fin_cycle_d;
      fin_instr_q <= fin_instr_d;
      fin_pc_q    <= fin_pc_d;
    end
  end

  assign running_o    = in_run;
  assign done_o       = done_q;
  assign done_pulse_o = pulse_q;
  assign pass_o       = pass_q;
  assign fail_o       = fail_q;
  assign timeout_o    = tmo_q;
  assign cause_o      = cause_q;
  assign src_idx_o    = idx_q;
  assign exit_value_o = exit_q;
  assign fin_cycle_o  = fin_cycle_q;
  assign fin_instr_o  = fin_instr_q;
  assign fin_pc_o     = fin_pc_q;
  assign cycle_cnt_o  = cycle_cnt;
  assign instr_cnt_o  = instr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tb_run_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tb_run_monitor : directed self-checking bench for tb_run_monitor|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_tb_run_monitor;

  logic         clk_i = 1'b0;
  logic         rst_i, rst_b;
  logic         retire_i;
  logic [31:0]  pc_i;
  logic [31:0]  max_cycles_i;
  logic [3:0]   src_valid_i;
  logic [127:0] src_value_i;

  logic        running_o, done_o, done_pulse_o, pass_o, fail_o, timeout_o;
  logic [1:0]  cause_o, src_idx_o;
  logic [31:0] exit_value_o, fin_cycle_o, fin_instr_o, fin_pc_o, cycle_cnt_o, instr_cnt_o;

  logic [7:0]   max_b;
  logic [3:0]   srcv_b;
  logic [127:0] srcd_b;
  logic         run_b, done_b, pulse_b, pass_b, fail_b, tmo_b;
  logic [1:0]   cause_b, idx_b;
  logic [31:0]  exit_b, finpc_b;
  logic [7:0]   fincyc_b, fininst_b, cyc_b, inst_b;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;

  always #5 clk_i = ~clk_i;

  tb_run_monitor #(
    .N_SRC(4), .VAL_W(32), .CNT_W(32), .STARTUP_CYCLES(2),
    .FAIL_MASK(4'b0100), .WDOG_CYCLES(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .retire_i(retire_i), .pc_i(pc_i),
    .max_cycles_i(max_cycles_i), .src_valid_i(src_valid_i), .src_value_i(src_value_i),
    .running_o(running_o), .done_o(done_o), .done_pulse_o(done_pulse_o),
    .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o), .cause_o(cause_o),
    .src_idx_o(src_idx_o), .exit_value_o(exit_value_o), .fin_cycle_o(fin_cycle_o),
    .fin_instr_o(fin_instr_o), .fin_pc_o(fin_pc_o), .cycle_cnt_o(cycle_cnt_o),
    .instr_cnt_o(instr_cnt_o)
  );

  tb_run_monitor #(
    .N_SRC(4), .VAL_W(32), .CNT_W(8), .STARTUP_CYCLES(2),
    .FAIL_MASK(4'b0000), .WDOG_CYCLES(16)
  ) dut_b (
    .clk_i(clk_i), .rst_i(rst_b), .retire_i(1'b1), .pc_i(pc_i),
    .max_cycles_i(max_b), .src_valid_i(srcv_b), .src_value_i(srcd_b),
    .running_o(run_b), .done_o(done_b), .done_pulse_o(pulse_b),
    .pass_o(pass_b), .fail_o(fail_b), .timeout_o(tmo_b), .cause_o(cause_b),
    .src_idx_o(idx_b), .exit_value_o(exit_b), .fin_cycle_o(fincyc_b),
    .fin_instr_o(fininst_b), .fin_pc_o(finpc_b), .cycle_cnt_o(cyc_b),
    .instr_cnt_o(inst_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Reset for two edges, then three edges of hold-off land the monitor in RUN.
  task automatic restart();
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
    tick(3);
  endtask

  task automatic wait_done(input int budget);
    pulses = 0;
    for (int i = 0; i < budget && !done_o; i++) begin
      tick(1);
      if (done_pulse_o) pulses++;
    end
    check("wait_done_bound", done_o, 1'b1);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; rst_b = 1'b1; retire_i = 1'b0; pc_i = 32'h0;
    max_cycles_i = 32'd0; src_valid_i = 4'b0; src_value_i = '0;
    max_b = 8'd0; srcv_b = 4'b0; srcd_b = '0;
    tick(3);
    check("rst_running", running_o, 0);
    check("rst_done",    done_o, 0);
    check("rst_cycle",   cycle_cnt_o, 0);
    check("rst_cause",   cause_o, 0);

    // Hold-off: running rises on the third edge after release.
    rst_i = 1'b0; rst_b = 1'b0;
    tick(2);
    check("holdoff_e2", running_o, 0);
    tick(1);
    check("holdoff_e3", running_o, 1);
    check("run_cycle0", cycle_cnt_o, 0);
    tick(5);
    check("run_cycle5", cycle_cnt_o, 5);
    check("b_cycle5",   cyc_b, 5);
    check("run_instr0", instr_cnt_o, 0);

    // Max-cycle abort with retire every cycle (3 retires during hold-off).
    retire_i = 1'b1; max_cycles_i = 32'd100; pc_i = 32'h8000_0100;
    restart();
    wait_done(200);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (done_pulse_o) pulses++;
    end
    check("max_pulses",   pulses, 1);
    check("max_cause",    cause_o, 2);
    check("max_timeout",  timeout_o, 1);
    check("max_pass",     pass_o, 0);
    check("max_fail",     fail_o, 0);
    check("max_fincycle", fin_cycle_o, 100);
    check("max_fininstr", fin_instr_o, 103);
    check("max_finpc",    fin_pc_o, 32'h8000_0100);
    check("max_frozen",   cycle_cnt_o, 100);
    check("max_done",     done_o, 1);

    // One-cycle reset while in DONE clears everything.
    retire_i = 1'b0; max_cycles_i = 32'd0;
    rst_i = 1'b1;
    tick(1);
    check("rdone_done",     done_o, 0);
    check("rdone_timeout",  timeout_o, 0);
    check("rdone_cause",    cause_o, 0);
    check("rdone_fincycle", fin_cycle_o, 0);
    check("rdone_cycle",    cycle_cnt_o, 0);
    check("rdone_instr",    instr_cnt_o, 0);
    rst_i = 1'b0;
    tick(3);
    check("rdone_rerun", running_o, 1);

    // Simultaneous sources 1 and 2: lower index wins, value 0 passes.
    restart();
    tick(4);
    pc_i = 32'h0000_1234;
    src_value_i[32 +: 32] = 32'd0;
    src_value_i[64 +: 32] = 32'd7;
    src_valid_i = 4'b0110;
    tick(1);
    src_valid_i = 4'b0;
    check("s12_cause", cause_o, 1);
    check("s12_idx",   src_idx_o, 1);
    check("s12_pass",  pass_o, 1);
    check("s12_fail",  fail_o, 0);
    check("s12_exit",  exit_value_o, 0);
    check("s12_pulse", done_pulse_o, 1);
    check("s12_fincy", fin_cycle_o, 4);
    check("s12_finpc", fin_pc_o, 32'h0000_1234);
    tick(1);
    check("s12_pulse_gone", done_pulse_o, 0);
    check("s12_held",       done_o, 1);

    // Source 0 with nonzero value, asserted during hold-off.
    rst_i = 1'b1;
    tick(2);
    src_value_i[0 +: 32] = 32'd3;
    src_valid_i = 4'b0001;
    rst_i = 1'b0;
    tick(1);
    src_valid_i = 4'b0;
    check("s0_done",    done_o, 1);
    check("s0_fail",    fail_o, 1);
    check("s0_pass",    pass_o, 0);
    check("s0_exit",    exit_value_o, 3);
    check("s0_idx",     src_idx_o, 0);
    check("s0_running", running_o, 0);

    // Masked source 2 fails even with value 0.
    restart();
    src_value_i[64 +: 32] = 32'd0;
    src_valid_i = 4'b0100;
    tick(1);
    src_valid_i = 4'b0;
    check("s2m_fail", fail_o, 1);
    check("s2m_pass", pass_o, 0);
    check("s2m_idx",  src_idx_o, 2);

    // Source beats max-cycle on the same cycle.
    max_cycles_i = 32'd3;
    restart();
    tick(3);
    src_value_i[96 +: 32] = 32'd5;
    src_valid_i = 4'b1000;
    tick(1);
    src_valid_i = 4'b0; max_cycles_i = 32'd0;
    check("prio_cause",   cause_o, 1);
    check("prio_idx",     src_idx_o, 3);
    check("prio_timeout", timeout_o, 0);
    check("prio_exit",    exit_value_o, 5);

    // Watchdog: retire stops when cycle_cnt reaches 40.
    retire_i = 1'b1;
    restart();
    tick(40);
    check("wd_cycle40", cycle_cnt_o, 40);
    retire_i = 1'b0;
`ifdef TB_RUN_MON_WATCHDOG_EN
    wait_done(100);
    check("wd_cause",    cause_o, 3);
    check("wd_fincycle", fin_cycle_o, 56);
    check("wd_fininstr", fin_instr_o, 43);
    check("wd_timeout",  timeout_o, 1);
`else
    tick(100);
    check("nowd_done",  done_o, 0);
    check("nowd_cycle", cycle_cnt_o, 140);
`endif

    // Narrow counter parks at all-ones.
    tick(300);
    check("b_sat_cycle", cyc_b, 8'hFF);
    check("b_sat_instr", inst_b, 8'hFF);
    check("b_running",   run_b, 1);
    check("b_done",      done_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
